regfile: RTL and testbench
==========================

# regfile

Architectural register file for the 64-bit single-cycle/pipelined CPU, sitting directly upstream of the ALU. It holds the 32 general-purpose registers X0–X31. Its two read ports drive ALU Bus A and Bus B, and its write port accepts the writeback result. X31 is the hard-wired zero register (XZR), and same-cycle write-to-read forwarding is built in so a decode-stage read sees a writeback in progress.

## Interface
Parameters:
- DATA_WIDTH, 64, register width; must match ALU bus width
- ADDR_WIDTH, 5, register index width; register count is 2**ADDR_WIDTH

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- ReadRegister1  input  ADDR_WIDTH  index for port 1 (feeds ALU Bus A)
- ReadRegister2  input  ADDR_WIDTH  index for port 2 (feeds ALU Bus B / store data)
- WriteRegister  input  ADDR_WIDTH  destination index
- WriteData  input  DATA_WIDTH  writeback value
- RegWrite  input  1  write enable
- ReadData1  output  DATA_WIDTH  contents of ReadRegister1
- ReadData2  output  DATA_WIDTH  contents of ReadRegister2

## Operation
- Storage: 31 writable 64-bit registers, X0–X30. X31 has no storage.
- Write: on the rising edge with reset=0 and RegWrite=1, the register selected by WriteRegister captures WriteData.
  - Writes with WriteRegister=31 are discarded.
  - RegWrite=0 leaves all registers unchanged.
- Reset: on the rising edge with reset=1, all registers are cleared to 0. Reset has priority over a simultaneous write, which is lost.
- Read: both ports are combinational and independent. Both may address the same register.
- Per-port read priority, highest first:
  1. reset=1 -> 0
  2. read index = 31 -> 0
  3. RegWrite=1 and WriteRegister equals the read index -> WriteData (forwarding)
  4. otherwise -> stored contents
- Forwarding is never applied when WriteRegister=31.
- No internal state machine beyond register storage. Write enables are one-hot, decoded from WriteRegister and gated by RegWrite and reset.

## Timing
- Read latency: 0 cycles (combinational from ReadRegisterN, WriteRegister, WriteData, RegWrite and reset).
- Write latency:
  - Through forwarding, the value is visible on the read ports in the same cycle the write is presented.
  - The value is held in storage from the rising edge that ends that cycle.
- Reset value of outputs: ReadData1 = ReadData2 = 0 while reset is high. After reset deasserts, every index reads 0 until written.
- Reset mid-operation: a write presented in the same cycle as reset is not stored. Registers written in earlier cycles are cleared at that edge.
- Back-to-back writes to one register, cycle N then N+1: the N+1 read returns the forwarded N+1 value; the stored value after edge N+1 is the N+1 data.
- Boundary indices: index 0 is a normal register. Index 30 (link register) is a normal register. Index 31 always reads 0, for both ports, in all cycles.

## Structure
- Shared package cpu_pkg holds:
  - DATA_WIDTH (64)
  - ADDR_WIDTH (5)
  - NUM_REGS (32)
  - XZR_INDEX (5'd31)
  - typedef reg_idx_t (logic [4:0])
  - typedef word_t (logic [63:0])
- The ALU and later pipeline stages import the same package.
- Sub-module reg64: a 64-bit register with synchronous active-high reset and write enable. It is instantiated 31 times via generate, one per X0–X30.
- Write decode and read muxes/forwarding stay in regfile.

## Test plan
- Reset clears state:
  - Stimulus: write 64'hDEADBEEF_CAFEF00D to X5, then assert reset for 1 cycle.
  - Required: ReadData1 = 0 during reset, and ReadRegister1=5 reads 0 afterwards.
- Basic write/read:
  - Stimulus: write X1 = 64'h1 and X2 = 64'hFFFF_FFFF_FFFF_FFFF on successive cycles, then read ports 1/2 = X1/X2.
  - Required: 64'h1 and 64'hFFFF_FFFF_FFFF_FFFF respectively.
- XZR:
  - Stimulus: RegWrite=1, WriteRegister=31, WriteData=64'h1234, with both ports reading 31 during and after the write.
  - Required: both ports read 0 in every cycle, and no other register changes.
- Forwarding:
  - Stimulus: X7 holds 64'hA; present a write of 64'hB to X7 with ReadRegister2=7.
  - Required: ReadData2 = 64'hB in the same cycle, and 64'hB after the edge with RegWrite=0.
- Write disabled:
  - Stimulus: RegWrite=0, WriteRegister=3, WriteData=64'h55, with X3 = 64'h77 previously.
  - Required: X3 reads 64'h77 in that cycle and the next.
- Reset/write collision:
  - Stimulus: reset=1 and a write of 64'h99 to X10 in the same cycle.
  - Required: X10 reads 0 after the edge; ReadData shows 0 during that cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 64-bit CPU datapath.
// Holds the architectural widths, the register count, the XZR index and the
// common index/word types. It is used by the register file, the ALU and the
// later pipeline stages.
package cpu_pkg;

    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [63:0] word_t;

    localparam reg_idx_t XZR_INDEX = 5'd31;

endpackage

// File: rtl/regfile_reg64.sv
// reg64: one architectural register with synchronous active-high reset and
// write enable.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous clear, has priority over en
//   en    - load d on the next rising edge
//   d     - data in
//   q     - stored value
module reg64
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile.sv
// regfile: architectural register file X0..X31 with two combinational read
// ports, one write port, hard-wired zero register (highest index) and
// same-cycle write-to-read forwarding.
// Ports:
//   clk           - rising-edge clock
//   reset         - synchronous active-high clear of all registers
//   ReadRegister1 - read index, port 1 (ALU Bus A)
//   ReadRegister2 - read index, port 2 (ALU Bus B / store data)
//   WriteRegister - write destination index
//   WriteData     - writeback value
//   RegWrite      - write enable
//   ReadData1     - value read on port 1
//   ReadData2     - value read on port 2
module regfile #(
    parameter int unsigned DATA_WIDTH = cpu_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = cpu_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    input  logic [ADDR_WIDTH-1:0] WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2
);

    localparam int unsigned          NUM_ENTRIES = 2 ** ADDR_WIDTH;
    localparam int unsigned          NUM_STORED  = NUM_ENTRIES - 1;
    localparam logic [ADDR_WIDTH-1:0] XZR        = '1;

    // Entry XZR is a constant-zero slot so every index selects in range.
    logic [DATA_WIDTH-1:0] stored [NUM_ENTRIES];
    logic [NUM_STORED-1:0] we;
    logic                  wr_ok;

    // Writes to XZR and writes during reset never reach storage or the
    // forwarding path.
    assign wr_ok = RegWrite && !reset && (WriteRegister != XZR);

    always_comb begin
        we = '0;
        for (int unsigned i = 0; i < NUM_STORED; i++) begin
            we[i] = wr_ok && (WriteRegister == i[ADDR_WIDTH-1:0]);
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_ENTRIES; g++) begin : g_reg
            if (g == NUM_ENTRIES - 1) begin : g_xzr
                assign stored[g] = '0;
            end else begin : g_x
                reg64 #(.WIDTH(DATA_WIDTH)) u_reg (
                    .clk   (clk),
                    .reset (reset),
                    .en    (we[g]),
                    .d     (WriteData),
                    .q     (stored[g])
                );
            end
        end
    endgenerate

    always_comb begin
        ReadData1 = stored[ReadRegister1];
        if (reset || ReadRegister1 == XZR) begin
            ReadData1 = '0;
        end else if (wr_ok && WriteRegister == ReadRegister1) begin
            ReadData1 = WriteData;
        end
    end

    always_comb begin
        ReadData2 = stored[ReadRegister2];
        if (reset || ReadRegister2 == XZR) begin
            ReadData2 = '0;
        end else if (wr_ok && WriteRegister == ReadRegister2) begin
            ReadData2 = WriteData;
        end
    end

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

    logic        clk;
    logic        reset;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic        RegWrite;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    int n_checks;
    int n_fail;
    bit chk_en;

    logic [63:0] model [32];

    regfile #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Architectural view: 32 registers, X31 reads zero and ignores writes.
    function automatic logic [63:0] expect_read(input logic [4:0] idx);
        if (reset) return 64'h0;
        if (idx == 5'd31) return 64'h0;
        if (RegWrite && WriteRegister == idx) return WriteData;
        return model[idx];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] <= 64'h0;
        end else if (RegWrite && WriteRegister != 5'd31) begin
            model[WriteRegister] <= WriteData;
        end
    end

    // Compare process: outputs are combinational, so check every cycle
    // mid-period once the first reset has been applied.
    always @(negedge clk) begin
        logic [63:0] e1, e2;
        if (chk_en) begin
            e1 = expect_read(ReadRegister1);
            e2 = expect_read(ReadRegister2);
            n_checks += 2;
            if (ReadData1 !== e1) begin
                n_fail++;
                $display("FAIL model_rd1 t=%0t idx=%0d got=%h exp=%h", $time, ReadRegister1, ReadData1, e1);
            end
            if (ReadData2 !== e2) begin
                n_fail++;
                $display("FAIL model_rd2 t=%0t idx=%0d got=%h exp=%h", $time, ReadRegister2, ReadData2, e2);
            end
        end
    end

    task automatic drive(input logic rst, input logic we, input logic [4:0] wr,
                         input logic [63:0] wd, input logic [4:0] r1, input logic [4:0] r2);
        @(posedge clk);
        #1;
        reset         = rst;
        RegWrite      = we;
        WriteRegister = wr;
        WriteData     = wd;
        ReadRegister1 = r1;
        ReadRegister2 = r2;
        #2;
    endtask

    task automatic check_lit(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 64'h0;
        reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        ReadRegister1 = '0; ReadRegister2 = '0;

        drive(1, 0, 0, 0, 0, 0);
        check_lit("reset_rd1", ReadData1, 64'h0);
        chk_en = 1'b1;
        drive(1, 0, 0, 0, 5, 30);
        drive(0, 0, 0, 0, 5, 30);
        check_lit("post_reset_x5", ReadData1, 64'h0);
        check_lit("post_reset_x30", ReadData2, 64'h0);

        // Reset clears state
        drive(0, 1, 5, 64'hDEADBEEF_CAFEF00D, 5, 5);
        check_lit("fwd_x5", ReadData1, 64'hDEADBEEF_CAFEF00D);
        drive(0, 0, 0, 0, 5, 5);
        check_lit("stored_x5", ReadData1, 64'hDEADBEEF_CAFEF00D);
        drive(1, 0, 0, 0, 5, 5);
        check_lit("during_reset_rd1", ReadData1, 64'h0);
        drive(0, 0, 0, 0, 5, 5);
        check_lit("after_reset_x5", ReadData1, 64'h0);

        // Basic write/read
        drive(0, 1, 1, 64'h1, 0, 0);
        drive(0, 1, 2, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
        drive(0, 0, 0, 0, 1, 2);
        check_lit("basic_x1", ReadData1, 64'h1);
        check_lit("basic_x2", ReadData2, 64'hFFFF_FFFF_FFFF_FFFF);

        // XZR
        drive(0, 1, 31, 64'h1234, 31, 31);
        check_lit("xzr_wr_rd1", ReadData1, 64'h0);
        check_lit("xzr_wr_rd2", ReadData2, 64'h0);
        drive(0, 0, 31, 64'h1234, 31, 31);
        check_lit("xzr_after_rd1", ReadData1, 64'h0);
        check_lit("xzr_after_rd2", ReadData2, 64'h0);
        drive(0, 0, 0, 0, 1, 2);
        check_lit("xzr_x1_kept", ReadData1, 64'h1);
        check_lit("xzr_x2_kept", ReadData2, 64'hFFFF_FFFF_FFFF_FFFF);

        // Forwarding
        drive(0, 1, 7, 64'hA, 0, 7);
        drive(0, 1, 7, 64'hB, 7, 7);
        check_lit("fwd_x7_same", ReadData2, 64'hB);
        drive(0, 0, 7, 64'hC, 0, 7);
        check_lit("fwd_x7_stored", ReadData2, 64'hB);

        // Write disabled
        drive(0, 1, 3, 64'h77, 0, 0);
        drive(0, 0, 3, 64'h55, 3, 3);
        check_lit("wdis_x3_now", ReadData1, 64'h77);
        drive(0, 0, 3, 64'h55, 3, 3);
        check_lit("wdis_x3_next", ReadData2, 64'h77);

        // Boundary indices 0 and 30
        drive(0, 1, 0, 64'h0123_4567_89AB_CDEF, 0, 0);
        drive(0, 1, 30, 64'hFEDC_BA98_7654_3210, 0, 30);
        check_lit("x0_stored", ReadData1, 64'h0123_4567_89AB_CDEF);
        check_lit("x30_fwd", ReadData2, 64'hFEDC_BA98_7654_3210);

        // Reset/write collision
        drive(1, 1, 10, 64'h99, 10, 10);
        check_lit("coll_rd1", ReadData1, 64'h0);
        check_lit("coll_rd2", ReadData2, 64'h0);
        drive(0, 0, 0, 0, 10, 30);
        check_lit("coll_x10", ReadData1, 64'h0);
        check_lit("coll_x30_cleared", ReadData2, 64'h0);

        // Randomized traffic, biased toward index collisions and X31
        for (int n = 0; n < 3000; n++) begin
            logic [4:0]  wr, r1, r2;
            logic [63:0] wd;
            wr = 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) r1 = 5'd31;
            wd = {$urandom, $urandom};
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0), wr, wd, r1, r2);
        end

        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
